// File: rtl/riscv_csr_arbiter.sv
// riscv_csr_arbiter: shares the CSR port between the core (priority) and a valid/ready debug requester with a starvation-forced debug slot; define RISCV_CSR_ARB_DEBUG_WRITE_EN to let debug write codes through
module riscv_csr_arbiter #(
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset,
  input  logic [2:0]  core_csr_access__access,
  input  logic [11:0] core_csr_access__address,
  input  logic [31:0] core_csr_write_data,
  output logic [31:0] core_csr_data__read_data,
  output logic        core_csr_data__illegal_access,
  output logic        core_stall,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic [2:0]  dbg_req_access,
  input  logic [11:0] dbg_req_address,
  input  logic [31:0] dbg_req_data,
  output logic        dbg_resp_valid,
  input  logic        dbg_resp_ready,
  output logic [31:0] dbg_resp_data,
  output logic        dbg_resp_illegal,
  output logic [2:0]  csr_access__access,
  output logic [11:0] csr_access__address,
  output logic [31:0] csr_write_data,
  input  logic [31:0] csr_data__read_data,
  input  logic        csr_data__illegal_access,
  output logic        dbg_grant
);
  typedef enum logic [1:0] {IDLE, WAIT, FORCE, RESP} state_t;
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT - 1);
  state_t state, state_nx;
  logic [2:0] req_access;
  logic [11:0] req_address;
  logic [31:0] req_data;
  logic [7:0] starve_count;
  logic [31:0] resp_data;
  logic resp_illegal;
  logic core_busy;
  logic [2:0] dbg_code;
  logic dbg_forced_ill;
  assign core_busy = core_csr_access__access != 3'd0;
`ifdef RISCV_CSR_ARB_DEBUG_WRITE_EN
  assign dbg_code = req_access == 3'd0 ? 3'd2 : req_access;
  assign dbg_forced_ill = 1'b0;
`else
  assign dbg_code = 3'd2;
  assign dbg_forced_ill = req_access != 3'd0 && req_access != 3'd2;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      starve_count <= '0;
      resp_data <= '0;
      resp_illegal <= 1'b0;
    end else if (clk__enable) begin
      state <= state_nx;
      if (state == IDLE && dbg_req_valid)
        starve_count <= '0;
      else if (state == WAIT && core_busy)
        starve_count <= starve_count + 8'd1;
      if (dbg_grant) begin
        resp_data <= csr_data__read_data;
        resp_illegal <= csr_data__illegal_access | dbg_forced_ill;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (clk__enable && dbg_req_ready && dbg_req_valid) begin
      req_access <= dbg_req_access;
      req_address <= dbg_req_address;
      req_data <= dbg_req_data;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = dbg_req_valid ? WAIT : IDLE;
      WAIT:  state_nx = !core_busy ? RESP : starve_count == LIM ? FORCE : WAIT;
      FORCE: state_nx = RESP;
      RESP:  state_nx = dbg_resp_ready ? IDLE : RESP;
    endcase
  end
  assign dbg_req_ready = !reset && state == IDLE;
  assign dbg_resp_valid = !reset && state == RESP;
  assign core_stall = !reset && state == FORCE;
  assign dbg_grant = !reset && (state == FORCE || (state == WAIT && !core_busy));
  assign csr_access__access = reset ? 3'd0 : dbg_grant ? dbg_code : core_csr_access__access;
  assign csr_access__address = dbg_grant ? req_address : core_csr_access__address;
  assign csr_write_data = dbg_grant ? req_data : core_csr_write_data;
  assign core_csr_data__read_data = dbg_grant ? 32'd0 : csr_data__read_data;
  assign core_csr_data__illegal_access = !dbg_grant && csr_data__illegal_access;
  assign dbg_resp_data = resp_data;
  assign dbg_resp_illegal = resp_illegal;
endmodule

// File: tb/tb_riscv_csr_arbiter.sv
// tb_riscv_csr_arbiter: scoreboard bench for riscv_csr_arbiter against a small CSR block model
module tb_riscv_csr_arbiter;
  logic clk = 0, clk__enable = 1, reset = 1;
  logic [2:0] core_csr_access__access = 0;
  logic [11:0] core_csr_access__address = 0;
  logic [31:0] core_csr_write_data = 0;
  logic [31:0] core_csr_data__read_data;
  logic core_csr_data__illegal_access, core_stall;
  logic dbg_req_valid = 0, dbg_req_ready;
  logic [2:0] dbg_req_access = 0;
  logic [11:0] dbg_req_address = 0;
  logic [31:0] dbg_req_data = 0;
  logic dbg_resp_valid, dbg_resp_ready = 1;
  logic [31:0] dbg_resp_data;
  logic dbg_resp_illegal;
  logic [2:0] csr_access__access;
  logic [11:0] csr_access__address;
  logic [31:0] csr_write_data, csr_data__read_data;
  logic csr_data__illegal_access, dbg_grant;
  riscv_csr_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .clk__enable(clk__enable), .reset(reset),
    .core_csr_access__access(core_csr_access__access),
    .core_csr_access__address(core_csr_access__address),
    .core_csr_write_data(core_csr_write_data),
    .core_csr_data__read_data(core_csr_data__read_data),
    .core_csr_data__illegal_access(core_csr_data__illegal_access),
    .core_stall(core_stall),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_access(dbg_req_access), .dbg_req_address(dbg_req_address),
    .dbg_req_data(dbg_req_data),
    .dbg_resp_valid(dbg_resp_valid), .dbg_resp_ready(dbg_resp_ready),
    .dbg_resp_data(dbg_resp_data), .dbg_resp_illegal(dbg_resp_illegal),
    .csr_access__access(csr_access__access),
    .csr_access__address(csr_access__address),
    .csr_write_data(csr_write_data),
    .csr_data__read_data(csr_data__read_data),
    .csr_data__illegal_access(csr_data__illegal_access),
    .dbg_grant(dbg_grant)
  );
  always #5 clk = ~clk;
  logic [31:0] mscratch = 0, mtvec = 0, m_nv;
  logic m_wr;
  always_comb begin
    csr_data__read_data = 0;
    csr_data__illegal_access = 0;
    m_wr = csr_access__access inside {3'd1, 3'd3, 3'd6, 3'd7};
    case (csr_access__address)
      12'h340: csr_data__read_data = mscratch;
      12'h305: csr_data__read_data = mtvec;
      12'hC00, 12'hF14: csr_data__illegal_access = m_wr;
      default: csr_data__illegal_access = 1;
    endcase
    m_nv = csr_access__access == 3'd6 ? csr_data__read_data | csr_write_data :
           csr_access__access == 3'd7 ? csr_data__read_data & ~csr_write_data : csr_write_data;
  end
  always @(posedge clk)
    if (clk__enable && m_wr && !csr_data__illegal_access) begin
      if (csr_access__address == 12'h340) mscratch <= m_nv;
      if (csr_access__address == 12'h305) mtvec <= m_nv;
    end
  int n_checks = 0, n_errors = 0;
  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [32:0] sb[$];
  always @(negedge clk)
    if (dbg_resp_valid && dbg_resp_ready) begin
      if (sb.size() == 0) check("sb_unexpected_resp", 1, 0);
      else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("resp_data", dbg_resp_data, e[31:0]);
        check("resp_illegal", dbg_resp_illegal, e[32]);
      end
    end
  int g_cnt, s_cnt, lat, wt;
  logic [2:0] g_acc;
  task automatic dbg_txn(input logic [2:0] a, input logic [11:0] ad, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_i, input int hold, input int gap);
    sb.push_back({exp_i, exp_d});
    g_cnt = 0; s_cnt = 0; lat = 0; wt = 0; g_acc = 0;
    dbg_req_valid = 1; dbg_req_access = a; dbg_req_address = ad; dbg_req_data = d;
    @(negedge clk);
    while (!dbg_req_ready && wt < 20) begin wt++; @(negedge clk); end
    check("req_ready", dbg_req_ready, 1);
    @(posedge clk); #1;
    dbg_req_valid = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (gap > 0 && k == 2) clk__enable = 0;
      if (gap > 0 && k == 2 + gap) clk__enable = 1;
      @(negedge clk);
      if (dbg_grant) begin
        g_cnt++;
        g_acc = csr_access__access;
        check("core_data_masked", {core_csr_data__illegal_access, core_csr_data__read_data}, 0);
      end
      if (core_stall) s_cnt++;
      if (dbg_resp_valid) begin
        lat = k;
        for (int h = 0; h < hold; h++) begin
          check("hold_req_ready", dbg_req_ready, 0);
          check("hold_resp_data", {dbg_resp_illegal, dbg_resp_data}, {exp_i, exp_d});
          @(posedge clk); #1;
          if (h == hold - 1) dbg_resp_ready = 1;
          @(negedge clk);
        end
      end
      @(posedge clk); #1;
    end
    check("resp_seen", lat != 0, 1);
  endtask
  task automatic core_op(input logic [2:0] a, input logic [11:0] ad, input logic [31:0] d);
    core_csr_access__access = a; core_csr_access__address = ad; core_csr_write_data = d;
  endtask
  initial begin
    int bad;
    core_op(3'd2, 12'h340, 0);
    dbg_req_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", dbg_req_ready, 0);
    check("rst_resp_valid", dbg_resp_valid, 0);
    check("rst_stall", core_stall, 0);
    check("rst_grant", dbg_grant, 0);
    check("rst_csr_access", csr_access__access, 0);
    check("rst_resp_regs", {dbg_resp_illegal, dbg_resp_data}, 0);
    dbg_req_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    core_op(3'd1, 12'h340, 32'hDEADBEEF);
    @(negedge clk);
    check("idle_req_ready", dbg_req_ready, 1);
    check("core_pass_access", csr_access__access, 1);
    check("core_pass_wdata", csr_write_data, 32'hDEADBEEF);
    @(posedge clk); #1;
    core_op(0, 0, 0);
    dbg_txn(3'd2, 12'h340, 0, 32'hDEADBEEF, 0, 0, 0);
    check("t1_grant_cycles", g_cnt, 1);
    check("t1_latency", lat, 2);
    check("t1_code", g_acc, 2);
    core_op(3'd1, 12'h305, 32'h100);
    @(posedge clk); #1;
    core_op(0, 0, 0);
`ifdef RISCV_CSR_ARB_DEBUG_WRITE_EN
    dbg_txn(3'd6, 12'h305, 32'h0F, 32'h100, 0, 0, 0);
    check("set_code", g_acc, 6);
    check("set_mtvec", mtvec, 32'h10F);
`else
    dbg_txn(3'd6, 12'h305, 32'h0F, 32'h100, 1, 0, 0);
    check("set_code", g_acc, 2);
    check("set_mtvec", mtvec, 32'h100);
`endif
    check("set_latency", lat, 2);
    dbg_resp_ready = 0;
    dbg_txn(3'd0, 12'h340, 0, 32'hDEADBEEF, 0, 5, 0);
    check("code0_as_read", g_acc, 2);
    check("hold_latency", lat, 2);
    dbg_txn(3'd2, 12'h7C0, 0, 0, 1, 0, 0);
    check("next_accept_wait", wt, 0);
    core_op(3'd2, 12'hC00, 0);
    dbg_txn(3'd2, 12'hF14, 0, 0, 0, 0, 0);
    check("force_grant_cycles", g_cnt, 1);
    check("force_stall_cycles", s_cnt, 1);
    check("force_latency", lat, 6);
    @(negedge clk);
    check("core_resume_stall", core_stall, 0);
    check("core_resume_access", csr_access__access, 2);
    @(posedge clk); #1;
    dbg_txn(3'd2, 12'hF14, 0, 0, 0, 0, 3);
    check("gap_latency", lat, 9);
    check("gap_stall_cycles", s_cnt, 1);
    dbg_req_valid = 1; dbg_req_access = 3'd2; dbg_req_address = 12'hF14;
    @(negedge clk);
    check("rstw_accept_ready", dbg_req_ready, 1);
    @(posedge clk); #1;
    dbg_req_valid = 0;
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    check("rstw_grant", dbg_grant, 0);
    check("rstw_csr_access", csr_access__access, 0);
    @(posedge clk); #1;
    reset = 0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dbg_resp_valid || dbg_grant || !dbg_req_ready) bad++;
      @(posedge clk); #1;
    end
    check("rstw_idle_no_resp", bad, 0);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
